weight_row_mac: RTL

Downstream consumer of one 28 x 16-bit weight-row BRAM (negedge-clocked, 1-cycle read).
Sequences ADDR/EN to read weights 0..27 in lockstep with an incoming pixel stream. Computes the signed fixed-point dot product of the row and presents a saturated 16-bit partial sum to the neuron accumulator through a valid/ready handshake.
One instance per weight-row BRAM inside a layer-0 neuron.

---
 rtl/ann_pkg.sv | 29 ++
 rtl/row_mac_sat.sv | 25 ++
 rtl/weight_row_mac.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ann_pkg.sv
// Shared constants and types for the layer-0 neuron datapath (weight rows, sum stages).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ann_pkg;

  // Row geometry: one weight per pixel, BRAM depth equals row length.
  localparam int ROW_LEN   = 28;
  localparam int ADDR_W    = 5;
  // Q4.12 two's complement for weights, pixels and sums.
  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 12;
  // Holds ROW_LEN full-precision products without overflow.
  localparam int ACC_W     = 40;
  // Counter must hold ROW_LEN itself (value after the last pixel is taken).
  localparam int CNT_W     = $clog2(ROW_LEN + 1);

  // Row sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Saturation bounds of a DATA_W result, sign-extended to accumulator width.
  localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

endpackage

// File: rtl/row_mac_sat.sv
// Arithmetic right shift by FRAC_BITS (floor) then clamp an ACC_W value into DATA_W.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows input.
module row_mac_sat
  import ann_pkg::*;
(
  input  logic [ACC_W-1:0]  i_acc,
  output logic [DATA_W-1:0] o_sum
);

  logic [ACC_W-1:0] w_shifted;

  // Rescale the Q(2*frac) accumulator back to Q(frac), then clamp to the DATA_W range.
  always_comb begin
    w_shifted = $signed(i_acc) >>> FRAC_BITS;
    if ($signed(w_shifted) > $signed(SAT_MAX)) begin
      o_sum = SAT_MAX[DATA_W-1:0];
    end else if ($signed(w_shifted) < $signed(SAT_MIN)) begin
      o_sum = SAT_MIN[DATA_W-1:0];
    end else begin
      o_sum = w_shifted[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/weight_row_mac.sv
// Streams ROW_LEN pixels against a weight-row BRAM and emits the saturated Q4.12 dot product.
// Latency: 2 cycles from the last accepted pixel to o_out_valid; one pixel per cycle throughput.
// Backpressure: o_pix_ready only in RUN; result held in DONE until i_out_ready.
module weight_row_mac
  import ann_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_pix_in,
  input  logic              i_pix_valid,
  output logic              o_pix_ready,
  output logic [ADDR_W-1:0] o_w_addr,
  output logic              o_w_en,
  output logic              o_w_we,
  output logic [DATA_W-1:0] o_w_di,
  input  logic [DATA_W-1:0] i_w_do,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_out_valid,
  input  logic              i_out_ready
);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [ACC_W-1:0]    r_acc;
  logic [DATA_W-1:0]   r_pix;
  logic                r_ph1_valid;
  logic [ADDR_W-1:0]   r_w_addr;
  logic                r_w_en;
  logic [DATA_W-1:0]   r_sum;
  logic                r_out_valid;

  logic [2*DATA_W-1:0] w_prod;
  logic [ACC_W-1:0]    w_prod_ext;
  logic [ACC_W-1:0]    w_acc_nxt;
  logic [DATA_W-1:0]   w_sat;
  logic                w_pix_take;
  logic                w_last;

  // The BRAM is read-only from this block.
  assign o_w_we      = 1'b0;
  assign o_w_di      = '0;

  assign o_w_addr    = r_w_addr;
  assign o_w_en      = r_w_en;
  assign o_sum       = r_sum;
  assign o_out_valid = r_out_valid;

  // Ready is a pure function of state so the pixel source sees it without a cycle of lag.
  assign o_pix_ready = (r_state == RUN);
  assign w_pix_take  = o_pix_ready & i_pix_valid;
  assign w_last      = (r_cnt == CNT_W'(ROW_LEN - 1));

  // Full-precision signed product of the weight read last cycle and its matching pixel.
  assign w_prod      = $signed(i_w_do) * $signed(r_pix);
  assign w_prod_ext  = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
  assign w_acc_nxt   = r_ph1_valid ? (r_acc + w_prod_ext) : r_acc;

  // The final accumulate and rescale happen in the same cycle, so saturate the next value.
  row_mac_sat u_sat (
    .i_acc (w_acc_nxt),
    .o_sum (w_sat)
  );

  // Row sequencer: issue BRAM reads in step with accepted pixels, accumulate, publish.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_pix       <= '0;
      r_ph1_valid <= 1'b0;
      r_w_addr    <= '0;
      r_w_en      <= 1'b0;
      r_sum       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_w_en      <= 1'b0;
          r_ph1_valid <= 1'b0;
          if (i_start) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc <= w_acc_nxt;
          if (w_pix_take) begin
            r_w_addr    <= ADDR_W'(r_cnt);
            r_w_en      <= 1'b1;
            r_pix       <= i_pix_in;
            r_ph1_valid <= 1'b1;
            r_cnt       <= r_cnt + 1'b1;
            if (w_last) begin
              r_state <= DRAIN;
            end
          end else begin
            // A stall issues no read and leaves the address counter where it is.
            r_w_en      <= 1'b0;
            r_ph1_valid <= 1'b0;
          end
        end
        DRAIN: begin
          r_acc       <= w_acc_nxt;
          r_w_en      <= 1'b0;
          r_ph1_valid <= 1'b0;
          r_sum       <= w_sat;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          // Result stays frozen until the accumulator takes it; START is not looked at here.
          if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
